control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Constant `OPCODE_WIDTH, default 6, opcode width (from types.sv).
REQ-002 Constant `ALU_SEL_SIZE, default 4, ALU select width (from types.sv).
REQ-003 clk  in  1  clock, rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 codop  in  `OPCODE_WIDTH  opcode from datapath; valid from DECODE onward.
REQ-006 pcWrSel  out  2  PC source: 0 ALU result, 1 D register, 2 jump target.
REQ-007 pcCtrl  out  1  unconditional PC write strobe.
REQ-008 memAdrSel  out  1  memory address: 0 PC, 1 D register.
REQ-009 memWrCtl  out  1  memory write strobe.
REQ-010 aluOp  out  `ALU_SEL_SIZE  ALU function: ADD=0, SUB=1, AND=2, OR=3, EQ=4, PASSA=5.
REQ-011 aluASel  out  1  ALU A: 0 PC, 1 A register.
REQ-012 aluBSel  out  2  ALU B: 0 B register, 1 constant 4, 2 sign-extended imm.
REQ-013 regWCtl, regDataSel, regWSel  out  1/1/2  regfile write strobe; data 0 DM, 1 D; addr 0 ir[21:17], 1 ir[26:22], 2 r31.
REQ-014 retire  out  1  one-cycle pulse in each instruction's final state.
REQ-015 halted  out  1  high while in HALT.
REQ-016 illegal  out  1  high while in TRAP (tied 0 without CTRL_ILLEGAL_TRAP_EN).

Function
REQ-017 Moore FSM; all outputs SHALL be registered-state decodes with no codop combinational path except the DECODE dispatch.
REQ-018 Defaults in every state: strobes 0, selects 0, aluOp ADD; aluOp EQ SHALL appear only in BRANCH.
REQ-019 FETCH: memAdrSel 0, aluASel 0, aluBSel 1, ADD, pcWrSel 0, pcCtrl 1 -> WAIT.
REQ-020 WAIT: all defaults (IR -> codop pipeline settles, A/B loaded) -> DECODE.
REQ-021 DECODE: aluASel 0, aluBSel 2, ADD (branch target into D); dispatch on codop.
REQ-022 Opcodes: ADD 0x00, SUB 0x01, AND 0x02, OR 0x03, ADDI 0x08, LW 0x10, SW 0x11, BEQ 0x18, J 0x20, JAL 0x21, HALT 0x3F.
REQ-023 ADD/SUB/AND/OR: EXEC_R (aluASel 1, aluBSel 0, matching aluOp) -> WB_R (regWSel 0, regDataSel 1, regWCtl 1, retire) -> FETCH; 5 cycles.
REQ-024 ADDI: EXEC_I (aluASel 1, aluBSel 2, ADD) -> WB_I (regWSel 1, regDataSel 1, regWCtl 1, retire) -> FETCH; 5 cycles.
REQ-025 LW: MEM_ADDR (aluASel 1, aluBSel 2, ADD) -> MEM_RD (memAdrSel 1) -> MEM_WB (regWSel 1, regDataSel 0, regWCtl 1, retire) -> FETCH; 6 cycles.
REQ-026 SW: MEM_ADDR -> MEM_WR (memAdrSel 1, memWrCtl 1, retire) -> FETCH; 5 cycles.
REQ-027 BEQ: BRANCH (aluASel 1, aluBSel 0, EQ, pcWrSel 1, pcCtrl 0, retire) -> FETCH; 4 cycles; PC update by datapath equality.
REQ-028 J: JUMP (aluASel 0, pcWrSel 2, pcCtrl 1, retire) -> FETCH; 4 cycles.
REQ-029 JAL: JAL1 (aluASel 0, PASSA) -> JAL2 (regWSel 2, regDataSel 1, regWCtl 1, aluASel 0, pcWrSel 2, pcCtrl 1, retire) -> FETCH; 5 cycles.
REQ-030 HALT: halted 1, all strobes 0, retire once on entry, state held until reset.
REQ-031 Unlisted opcode: see Configuration.
REQ-032 memWrCtl, regWCtl, pcCtrl SHALL never assert in the same cycle except JAL2 (regWCtl+pcCtrl).

Reset
REQ-033 reset SHALL force state FETCH and all outputs to defaults (retire, halted, illegal 0) asynchronously, mid-instruction included.
REQ-034 First FETCH strobes SHALL appear in the first clk after reset deassertion.

Configuration
REQ-035 CTRL_ILLEGAL_TRAP_EN defined: unlisted opcode in DECODE -> TRAP (illegal 1, strobes 0, held until reset).
REQ-036 CTRL_ILLEGAL_TRAP_EN undefined: unlisted opcode -> NOP (DECODE retires, -> FETCH); illegal tied 0; no TRAP state.

Structure
REQ-037 Opcode constants, ALU select codes, mux select codes and the state enum SHALL reside in types.sv.
REQ-038 One sub-module ctrl_output_decode (combinational state->outputs); next-state logic and state register in control_unit.

Verification
REQ-039 reset mid-MEM_WR -> memWrCtl 0 immediately; after release FETCH, pcCtrl 1 first cycle.
REQ-040 codop 0x00 -> strobe trace FETCH,WAIT,DECODE,EXEC_R(aluOp 0),WB_R(regWCtl 1, regWSel 0); retire at cycle 5.
REQ-041 codop 0x10 -> MEM_RD memAdrSel 1, MEM_WB regDataSel 0, regWSel 1; retire at cycle 6; codop 0x11 -> memWrCtl 1 cycle 5.
REQ-042 codop 0x18 -> aluOp 4, pcWrSel 1, pcCtrl 0 in cycle 4; codop 0x21 -> JAL2 regWSel 2, pcWrSel 2, pcCtrl 1.
REQ-043 codop 0x3F -> halted 1 persists 100 cycles, no strobes; reset clears halted.
REQ-044 codop 0x2A -> with macro illegal 1 held; without macro retire in DECODE and FETCH next.

Source files
------------

// File: rtl/types.sv
//------------------------------------------------------------------------------
// types.sv : shared opcodes, ALU and mux select codes, FSM states and the
//            control-word struct for control_unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef ALU_SEL_SIZE
`define ALU_SEL_SIZE 4
`endif

package types_pkg;

    localparam int OPCODE_WIDTH = `OPCODE_WIDTH;
    localparam int ALU_SEL_SIZE = `ALU_SEL_SIZE;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [ALU_SEL_SIZE-1:0] alu_sel_t;

    localparam opcode_t OP_ADD  = opcode_t'(6'h00);
    localparam opcode_t OP_SUB  = opcode_t'(6'h01);
    localparam opcode_t OP_AND  = opcode_t'(6'h02);
    localparam opcode_t OP_OR   = opcode_t'(6'h03);
    localparam opcode_t OP_ADDI = opcode_t'(6'h08);
    localparam opcode_t OP_LW   = opcode_t'(6'h10);
    localparam opcode_t OP_SW   = opcode_t'(6'h11);
    localparam opcode_t OP_BEQ  = opcode_t'(6'h18);
    localparam opcode_t OP_J    = opcode_t'(6'h20);
    localparam opcode_t OP_JAL  = opcode_t'(6'h21);
    localparam opcode_t OP_HALT = opcode_t'(6'h3F);

    localparam alu_sel_t ALU_ADD   = alu_sel_t'(4'd0);
    localparam alu_sel_t ALU_SUB   = alu_sel_t'(4'd1);
    localparam alu_sel_t ALU_AND   = alu_sel_t'(4'd2);
    localparam alu_sel_t ALU_OR    = alu_sel_t'(4'd3);
    localparam alu_sel_t ALU_EQ    = alu_sel_t'(4'd4);
    localparam alu_sel_t ALU_PASSA = alu_sel_t'(4'd5);

    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_D    = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic       MEM_ADR_PC  = 1'b0;
    localparam logic       MEM_ADR_D   = 1'b1;
    localparam logic       ALU_A_PC    = 1'b0;
    localparam logic       ALU_A_REG   = 1'b1;
    localparam logic [1:0] ALU_B_REG   = 2'd0;
    localparam logic [1:0] ALU_B_FOUR  = 2'd1;
    localparam logic [1:0] ALU_B_IMM   = 2'd2;
    localparam logic       REG_DATA_DM = 1'b0;
    localparam logic       REG_DATA_D  = 1'b1;
    localparam logic [1:0] REG_W_IR21  = 2'd0;
    localparam logic [1:0] REG_W_IR26  = 2'd1;
    localparam logic [1:0] REG_W_R31   = 2'd2;

    typedef enum logic [4:0] {
        S_FETCH, S_WAIT, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
        S_JAL1, S_JAL2, S_HALT
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef struct packed {
        logic [1:0] pc_wr_sel;
        logic       pc_ctrl;
        logic       mem_adr_sel;
        logic       mem_wr_ctl;
        alu_sel_t   alu_op;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       reg_w_ctl;
        logic       reg_data_sel;
        logic [1:0] reg_w_sel;
        logic       retire;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '0;

    function automatic logic is_listed(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) ||
               (op == OP_JAL) || (op == OP_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_ctrl_output_decode.sv
//------------------------------------------------------------------------------
// ctrl_output_decode : combinational state -> control word decode.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_output_decode
    import types_pkg::*;
(
    input  state_t state,
    input  logic   active,
    input  logic   held,
    input  logic   nop,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = CTRL_DEFAULT;
        ctrl.alu_op = ALU_ADD;
        // Nothing drives the datapath until the first post-reset edge.
        if (active) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_adr_sel = MEM_ADR_PC;
                    ctrl.alu_a_sel   = ALU_A_PC;
                    ctrl.alu_b_sel   = ALU_B_FOUR;
                    ctrl.pc_wr_sel   = PC_SRC_ALU;
                    ctrl.pc_ctrl     = 1'b1;
                end
                S_DECODE: begin
                    ctrl.alu_a_sel = ALU_A_PC;
                    ctrl.alu_b_sel = ALU_B_IMM;
                    ctrl.retire    = nop;
                end
                S_EXEC_R: ctrl.alu_a_sel = ALU_A_REG;
                S_WB_R: begin
                    ctrl.reg_w_sel    = REG_W_IR21;
                    ctrl.reg_data_sel = REG_DATA_D;
                    ctrl.reg_w_ctl    = 1'b1;
                    ctrl.retire       = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    ctrl.alu_a_sel = ALU_A_REG;
                    ctrl.alu_b_sel = ALU_B_IMM;
                end
                S_WB_I: begin
                    ctrl.reg_w_sel    = REG_W_IR26;
                    ctrl.reg_data_sel = REG_DATA_D;
                    ctrl.reg_w_ctl    = 1'b1;
                    ctrl.retire       = 1'b1;
                end
                S_MEM_RD: ctrl.mem_adr_sel = MEM_ADR_D;
                S_MEM_WB: begin
                    ctrl.reg_w_sel    = REG_W_IR26;
                    ctrl.reg_data_sel = REG_DATA_DM;
                    ctrl.reg_w_ctl    = 1'b1;
                    ctrl.retire       = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_adr_sel = MEM_ADR_D;
                    ctrl.mem_wr_ctl  = 1'b1;
                    ctrl.retire      = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_a_sel = ALU_A_REG;
                    ctrl.alu_b_sel = ALU_B_REG;
                    ctrl.alu_op    = ALU_EQ;
                    ctrl.pc_wr_sel = PC_SRC_D;
                    ctrl.retire    = 1'b1;
                end
                S_JUMP: begin
                    ctrl.alu_a_sel = ALU_A_PC;
                    ctrl.pc_wr_sel = PC_SRC_JUMP;
                    ctrl.pc_ctrl   = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                S_JAL1: begin
                    ctrl.alu_a_sel = ALU_A_PC;
                    ctrl.alu_op    = ALU_PASSA;
                end
                S_JAL2: begin
                    ctrl.reg_w_sel    = REG_W_R31;
                    ctrl.reg_data_sel = REG_DATA_D;
                    ctrl.reg_w_ctl    = 1'b1;
                    ctrl.alu_a_sel    = ALU_A_PC;
                    ctrl.pc_wr_sel    = PC_SRC_JUMP;
                    ctrl.pc_ctrl      = 1'b1;
                    ctrl.retire       = 1'b1;
                end
                S_HALT: begin
                    ctrl.halted = 1'b1;
                    ctrl.retire = ~held;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: ctrl.illegal = 1'b1;
`endif
                default: ctrl = CTRL_DEFAULT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// control_unit : multi-cycle Moore controller; state register and next state.
// Optional illegal-opcode trap enabled by CTRL_ILLEGAL_TRAP_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_unit
    import types_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] codop,
    output logic [1:0]              pcWrSel,
    output logic                    pcCtrl,
    output logic                    memAdrSel,
    output logic                    memWrCtl,
    output logic [ALU_SEL_SIZE-1:0] aluOp,
    output logic                    aluASel,
    output logic [1:0]              aluBSel,
    output logic                    regWCtl,
    output logic                    regDataSel,
    output logic [1:0]              regWSel,
    output logic                    retire,
    output logic                    halted,
    output logic                    illegal
);

    state_t state;
    logic   active;
    logic   held;
    logic   nop;
    ctrl_t  ctrl;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign nop = 1'b0;
`else
    assign nop = (state == S_DECODE) && !is_listed(codop);
`endif

    // 'active' holds the machine in a quiet FETCH until the first edge after
    // reset, so FETCH strobes occupy exactly the first post-reset cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            active <= 1'b0;
            held   <= 1'b0;
        end else begin
            active <= 1'b1;
            held   <= active && (state == S_HALT);
            if (active) begin
                case (state)
                    S_FETCH:  state <= S_WAIT;
                    S_WAIT:   state <= S_DECODE;
                    S_DECODE: begin
                        case (codop)
                            OP_ADD, OP_SUB, OP_AND, OP_OR: state <= S_EXEC_R;
                            OP_ADDI:       state <= S_EXEC_I;
                            OP_LW, OP_SW:  state <= S_MEM_ADDR;
                            OP_BEQ:        state <= S_BRANCH;
                            OP_J:          state <= S_JUMP;
                            OP_JAL:        state <= S_JAL1;
                            OP_HALT:       state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                            default:       state <= S_TRAP;
`else
                            default:       state <= S_FETCH;
`endif
                        endcase
                    end
                    S_EXEC_R:   state <= S_WB_R;
                    S_EXEC_I:   state <= S_WB_I;
                    S_MEM_ADDR: state <= (codop == OP_SW) ? S_MEM_WR : S_MEM_RD;
                    S_MEM_RD:   state <= S_MEM_WB;
                    S_JAL1:     state <= S_JAL2;
                    S_HALT:     state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    S_TRAP:     state <= S_TRAP;
`endif
                    default:    state <= S_FETCH;
                endcase
            end
        end
    end

    ctrl_output_decode u_decode (
        .state  (state),
        .active (active),
        .held   (held),
        .nop    (nop),
        .ctrl   (ctrl)
    );

    // R-type ALU function comes straight from the low opcode bits in EXEC_R.
    always_comb begin
        aluOp = ctrl.alu_op;
        if (state == S_EXEC_R && active) begin
            aluOp = ALU_ADD;
            case (codop)
                OP_SUB:  aluOp = ALU_SUB;
                OP_AND:  aluOp = ALU_AND;
                OP_OR:   aluOp = ALU_OR;
                default: aluOp = ALU_ADD;
            endcase
        end
    end

    assign pcWrSel    = ctrl.pc_wr_sel;
    assign pcCtrl     = ctrl.pc_ctrl;
    assign memAdrSel  = ctrl.mem_adr_sel;
    assign memWrCtl   = ctrl.mem_wr_ctl;
    assign aluASel    = ctrl.alu_a_sel;
    assign aluBSel    = ctrl.alu_b_sel;
    assign regWCtl    = ctrl.reg_w_ctl;
    assign regDataSel = ctrl.reg_data_sel;
    assign regWSel    = ctrl.reg_w_sel;
    assign retire     = ctrl.retire;
    assign halted     = ctrl.halted;
    assign illegal    = ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// tb_control_unit : directed vector bench for control_unit. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] codop = 6'h00;
    logic [1:0] pcWrSel;
    logic       pcCtrl;
    logic       memAdrSel;
    logic       memWrCtl;
    logic [3:0] aluOp;
    logic       aluASel;
    logic [1:0] aluBSel;
    logic       regWCtl;
    logic       regDataSel;
    logic [1:0] regWSel;
    logic       retire;
    logic       halted;
    logic       illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .codop(codop),
        .pcWrSel(pcWrSel), .pcCtrl(pcCtrl), .memAdrSel(memAdrSel),
        .memWrCtl(memWrCtl), .aluOp(aluOp), .aluASel(aluASel),
        .aluBSel(aluBSel), .regWCtl(regWCtl), .regDataSel(regDataSel),
        .regWSel(regWSel), .retire(retire), .halted(halted),
        .illegal(illegal)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        int          cyc;
        logic [18:0] exp;
    } vec_t;

    function automatic logic [18:0] mk(
        input logic [1:0] pws, input logic pc, input logic mas, input logic mw,
        input logic [3:0] op, input logic as, input logic [1:0] bs,
        input logic rw, input logic rd, input logic [1:0] rs,
        input logic ret, input logic h, input logic il);
        return {pws, pc, mas, mw, op, as, bs, rw, rd, rs, ret, h, il};
    endfunction

    function automatic logic [18:0] got();
        return {pcWrSel, pcCtrl, memAdrSel, memWrCtl, aluOp, aluASel, aluBSel,
                regWCtl, regDataSel, regWSel, retire, halted, illegal};
    endfunction

    task automatic check(input string name, input logic [18:0] exp);
        checks++;
        if (got() !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, got(), exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with the opcode already on codop, release at a falling edge.
    task automatic restart(input logic [5:0] op);
        reset = 1'b1;
        codop = op;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[$];
    logic [18:0] fetch_w, decode_w, zero_w;
    int bad;

    initial begin
        fetch_w  = mk(0,1,0,0,0,0,1,0,0,0,0,0,0);
        decode_w = mk(0,0,0,0,0,0,2,0,0,0,0,0,0);
        zero_w   = '0;

        vecs.push_back('{"add_fetch",   6'h00, 1, fetch_w});
        vecs.push_back('{"add_wait",    6'h00, 2, zero_w});
        vecs.push_back('{"add_decode",  6'h00, 3, decode_w});
        vecs.push_back('{"add_exec",    6'h00, 4, mk(0,0,0,0,0,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"add_wb",      6'h00, 5, mk(0,0,0,0,0,0,0,1,1,0,1,0,0)});
        vecs.push_back('{"add_refetch", 6'h00, 6, fetch_w});
        vecs.push_back('{"sub_exec",    6'h01, 4, mk(0,0,0,0,1,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"and_exec",    6'h02, 4, mk(0,0,0,0,2,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"or_exec",     6'h03, 4, mk(0,0,0,0,3,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"addi_exec",   6'h08, 4, mk(0,0,0,0,0,1,2,0,0,0,0,0,0)});
        vecs.push_back('{"addi_wb",     6'h08, 5, mk(0,0,0,0,0,0,0,1,1,1,1,0,0)});
        vecs.push_back('{"lw_addr",     6'h10, 4, mk(0,0,0,0,0,1,2,0,0,0,0,0,0)});
        vecs.push_back('{"lw_rd",       6'h10, 5, mk(0,0,1,0,0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"lw_wb",       6'h10, 6, mk(0,0,0,0,0,0,0,1,0,1,1,0,0)});
        vecs.push_back('{"lw_refetch",  6'h10, 7, fetch_w});
        vecs.push_back('{"sw_wr",       6'h11, 5, mk(0,0,1,1,0,0,0,0,0,0,1,0,0)});
        vecs.push_back('{"sw_refetch",  6'h11, 6, fetch_w});
        vecs.push_back('{"beq_branch",  6'h18, 4, mk(1,0,0,0,4,1,0,0,0,0,1,0,0)});
        vecs.push_back('{"beq_refetch", 6'h18, 5, fetch_w});
        vecs.push_back('{"j_jump",      6'h20, 4, mk(2,1,0,0,0,0,0,0,0,0,1,0,0)});
        vecs.push_back('{"jal_1",       6'h21, 4, mk(0,0,0,0,5,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"jal_2",       6'h21, 5, mk(2,1,0,0,0,0,0,1,1,2,1,0,0)});
        vecs.push_back('{"halt_entry",  6'h3F, 4, mk(0,0,0,0,0,0,0,0,0,0,1,1,0)});
        vecs.push_back('{"halt_hold",   6'h3F, 5, mk(0,0,0,0,0,0,0,0,0,0,0,1,0)});
`ifdef CTRL_ILLEGAL_TRAP_EN
        vecs.push_back('{"ill_decode",  6'h2A, 3, decode_w});
        vecs.push_back('{"ill_trap",    6'h2A, 4, mk(0,0,0,0,0,0,0,0,0,0,0,0,1)});
        vecs.push_back('{"ill_hold",    6'h2A, 9, mk(0,0,0,0,0,0,0,0,0,0,0,0,1)});
`else
        vecs.push_back('{"nop_decode",  6'h2A, 3, mk(0,0,0,0,0,0,2,0,0,0,1,0,0)});
        vecs.push_back('{"nop_refetch", 6'h2A, 4, fetch_w});
`endif

        // Outputs held at defaults while reset is asserted.
        #1;
        check("reset_state", zero_w);

        foreach (vecs[i]) begin
            restart(vecs[i].op);
            step(vecs[i].cyc);
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset in the middle of MEM_WR.
        restart(6'h11);
        step(5);
        check("sw_before_reset", mk(0,0,1,1,0,0,0,0,0,0,1,0,0));
        #2 reset = 1'b1;
        #1 check("async_reset_midwr", zero_w);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        check("fetch_after_reset", fetch_w);

        // HALT persists without strobes for 100 cycles, then reset clears it.
        restart(6'h3F);
        step(4);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (got() !== mk(0,0,0,0,0,0,0,0,0,0,0,1,0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_persist bad_cycles=%0d required=0", bad);
        end
        reset = 1'b1;
        #1 check("halt_cleared", zero_w);

        // Strobe exclusivity over a mixed program (JAL2 may pair regW+pc).
        restart(6'h21);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if ((memWrCtl && (regWCtl || pcCtrl)) ||
                (regWCtl && pcCtrl && !(regWSel == 2'd2 && pcWrSel == 2'd2)))
                bad++;
            if (c == 9) codop = 6'h11;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL strobe_exclusive bad_cycles=%0d required=0", bad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
